// File: rtl/nanoz80_pkg.sv
// nanoz80_pkg: shared constants for the nanoz80 I/O peripherals.
//   - register offsets of the timer/interrupt controller page
//   - CTRL register bit positions
//   - interrupt source indices
package nanoz80_pkg;

   // Register offsets, selected by cpu_addr[3:0]
   localparam logic [3:0] REG_CTRL      = 4'd0;
   localparam logic [3:0] REG_RELOAD_LO = 4'd1;
   localparam logic [3:0] REG_RELOAD_HI = 4'd2;
   localparam logic [3:0] REG_PRESCALE  = 4'd3;
   localparam logic [3:0] REG_STATUS    = 4'd4;
   localparam logic [3:0] REG_MASK      = 4'd5;
   localparam logic [3:0] REG_VECTOR    = 4'd6;
   localparam logic [3:0] REG_COUNT_LO  = 4'd7;
   localparam logic [3:0] REG_COUNT_HI  = 4'd8;

   // CTRL bit positions
   localparam int CTRL_RUN  = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IE   = 7;

   // Interrupt sources; lower index = higher priority
   localparam int SRC_TIMER = 0;
   localparam int SRC_UART  = 1;
   localparam int SRC_EXT   = 2;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder.
//   req   in  N   request vector
//   idx   out 2   index of the lowest set bit (0 when none set)
//   valid out 1   at least one request bit set
module irq_prio_enc #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   output logic [1:0]   idx,
   output logic         valid
);

   // Scan from the top down so the lowest set index is assigned last.
   always_comb begin
      idx   = 2'd0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = 2'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_timer.sv
// irq_timer: programmable interval timer plus 3-source Z80 IM2 interrupt
// controller on the I/O bus.
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   wr_n, rd_n, m1_n,
//   ioreq_n               Z80 bus strobes (active-low)
//   reg_addr_i, data_i    register select and write data
//   timer_cs              chip select from the address decoder
//   uart_irq_i, ext_irq_i level interrupt requests (asynchronous)
//   data_o                registered read data, or IM2 vector during ack
//   vec_cs_o              data_o carries the vector
//   int_n_o               Z80 INT, active-low
module irq_timer
   import nanoz80_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int PRESCALE_W = 8
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       wr_n,
   input  logic       rd_n,
   input  logic       m1_n,
   input  logic       ioreq_n,
   input  logic [3:0] reg_addr_i,
   input  logic [7:0] data_i,
   input  logic       timer_cs,
   input  logic       uart_irq_i,
   input  logic       ext_irq_i,
   output logic [7:0] data_o,
   output logic       vec_cs_o,
   output logic       int_n_o
);

   logic                  wr_act, wr_act_q, wr_pulse;
   logic                  rd_act, rd_act_q, rd_pulse;
   logic                  ack, ack_q, ack_first, ack_last;
   logic                  run_reg, auto_reg, ie_reg;
   logic [15:0]           reload_reg, count_reg;
   logic [PRESCALE_W-1:0] prescale_reg, presc_cnt_reg;
   logic [NUM_SRC-1:0]    pending_reg, mask_reg, set_vec, clr_vec;
   logic [7:0]            vector_reg, shadow_reg, data_reg, rd_mux;
   logic                  vec_cs_reg, int_n_reg;
   logic [1:0]            win_reg, enc_idx, win_now;
   logic                  win_valid_reg, enc_valid;
   logic                  wr_ctrl, wr_status, run_start, tick, expire;
   logic [NUM_SRC-1:1]    src_lvl;

   // Edge detection on the bus strobes: a held strobe acts only once.
   assign wr_act    = timer_cs & ~wr_n;
   assign wr_pulse  = wr_act & ~wr_act_q;
   assign rd_act    = timer_cs & ~rd_n;
   assign rd_pulse  = rd_act & ~rd_act_q;
   assign ack       = ~m1_n & ~ioreq_n;
   assign ack_first = ack & ~ack_q;
   assign ack_last  = ~ack & ack_q;

   assign wr_ctrl   = wr_pulse && (reg_addr_i == REG_CTRL);
   assign wr_status = wr_pulse && (reg_addr_i == REG_STATUS);
   assign run_start = wr_ctrl & data_i[CTRL_RUN] & ~run_reg;
   assign tick      = run_reg && (presc_cnt_reg == prescale_reg);
   assign expire    = tick && (count_reg == 16'd0);

   // Winner index; 3 marks a spurious acknowledge.
   irq_prio_enc #(.N(NUM_SRC)) u_prio (
      .req   (pending_reg & mask_reg),
      .idx   (enc_idx),
      .valid (enc_valid)
   );
   assign win_now = enc_valid ? enc_idx : 2'd3;

   // External level sources: 2-flop synchroniser plus an edge flop.
   assign src_lvl = {ext_irq_i, uart_irq_i};
   assign set_vec[SRC_TIMER] = expire;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_SRC; gi++) begin : g_src
         logic [2:0] sync_reg;
         always_ff @(posedge clk_i) begin
            if (!rst_n_i) sync_reg <= 3'b000;
            else          sync_reg <= {sync_reg[1:0], src_lvl[gi]};
         end
         assign set_vec[gi] = sync_reg[1] & ~sync_reg[2];
      end
   endgenerate

   always_comb begin
      clr_vec = '0;
      if (wr_status)
         clr_vec = data_i[NUM_SRC-1:0];
      if (ack_last && win_valid_reg)
         clr_vec = clr_vec | (NUM_SRC'(1) << win_reg);
   end

   always_comb begin
      rd_mux = 8'h00;
      case (reg_addr_i)
         REG_CTRL:      rd_mux = {ie_reg, 5'b00000, auto_reg, run_reg};
         REG_RELOAD_LO: rd_mux = reload_reg[7:0];
         REG_RELOAD_HI: rd_mux = reload_reg[15:8];
         REG_PRESCALE:  rd_mux = 8'(prescale_reg);
         REG_STATUS:    rd_mux = 8'(pending_reg);
         REG_MASK:      rd_mux = 8'(mask_reg);
         REG_VECTOR:    rd_mux = vector_reg;
         REG_COUNT_LO:  rd_mux = count_reg[7:0];
         REG_COUNT_HI:  rd_mux = shadow_reg;
         default:       rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         // Follow the live strobe so a write still held across reset
         // release is not seen as a fresh edge.
         wr_act_q      <= wr_act;
         rd_act_q      <= 1'b0;
         ack_q         <= 1'b0;
         run_reg       <= 1'b0;
         auto_reg      <= 1'b0;
         ie_reg        <= 1'b0;
         reload_reg    <= 16'h0000;
         count_reg     <= 16'h0000;
         prescale_reg  <= '0;
         presc_cnt_reg <= '0;
         pending_reg   <= '0;
         mask_reg      <= '0;
         vector_reg    <= 8'h00;
         shadow_reg    <= 8'h00;
         data_reg      <= 8'h00;
         vec_cs_reg    <= 1'b0;
         int_n_reg     <= 1'b1;
         win_reg       <= 2'd0;
         win_valid_reg <= 1'b0;
      end else begin
         wr_act_q <= wr_act;
         rd_act_q <= rd_act;
         ack_q    <= ack;

         // Register writes
         if (wr_pulse) begin
            case (reg_addr_i)
               REG_CTRL: begin
                  auto_reg <= data_i[CTRL_AUTO];
                  ie_reg   <= data_i[CTRL_IE];
               end
               REG_RELOAD_LO: reload_reg[7:0]  <= data_i;
               REG_RELOAD_HI: reload_reg[15:8] <= data_i;
               REG_PRESCALE:  prescale_reg     <= PRESCALE_W'(data_i);
               REG_MASK:      mask_reg         <= data_i[NUM_SRC-1:0];
               REG_VECTOR:    vector_reg       <= data_i;
               default: ;
            endcase
         end

         // A CTRL write overrides the one-shot self-stop.
         if (wr_ctrl)
            run_reg <= data_i[CTRL_RUN];
         else if (expire && !auto_reg)
            run_reg <= 1'b0;

         // Counter and prescaler
         if (run_start) begin
            count_reg     <= reload_reg;
            presc_cnt_reg <= '0;
         end else if (run_reg) begin
            if (tick) begin
               presc_cnt_reg <= '0;
               if (count_reg == 16'd0) begin
                  if (auto_reg) count_reg <= reload_reg;
               end else begin
                  count_reg <= count_reg - 16'd1;
               end
            end else begin
               presc_cnt_reg <= presc_cnt_reg + PRESCALE_W'(1);
            end
         end

         // COUNT_HI is captured together with the COUNT_LO read.
         if (rd_pulse && (reg_addr_i == REG_COUNT_LO))
            shadow_reg <= count_reg[15:8];

         // New events win over any clear in the same cycle.
         pending_reg <= (pending_reg & ~clr_vec) | set_vec;

         if (ack_first) begin
            win_reg       <= win_now;
            win_valid_reg <= enc_valid;
         end

         vec_cs_reg <= ack;
         if (ack)
            data_reg <= {vector_reg[7:3], (ack_first ? win_now : win_reg), 1'b0};
         else
            data_reg <= rd_mux;

         int_n_reg <= ~(ie_reg & (|(pending_reg & mask_reg)));
      end
   end

   assign data_o   = data_reg;
   assign vec_cs_o = vec_cs_reg;
   assign int_n_o  = int_n_reg;

endmodule

// File: doc/irq_timer.md
Name: irq_timer

Overview:
- Memory-mapped programmable interval timer plus a 3-source Z80 interrupt controller on the I/O bus.
- Sits upstream of the CPU. It drives the CPU maskable-interrupt input, which is currently tied high.
- During an interrupt-acknowledge cycle it supplies the IM2 vector byte into the CPU data input mux, alongside ROM, RAM, UART, LEDs and the address decoder.
- The address decoder gains a timer_cs output for I/O page 0x2x.

Parameters:
- NUM_SRC, 3, number of interrupt sources (0 = timer, 1 = UART, 2 = external). Fixed at ≤4.
- PRESCALE_W, 8, prescaler register width in bits.

Ports:
- clk_i  in  1  system clock, same clock as the CPU.
- rst_n_i  in  1  reset, synchronous, active-low.
- wr_n  in  1  CPU write strobe, active-low.
- rd_n  in  1  CPU read strobe, active-low.
- m1_n  in  1  CPU M1, active-low.
- ioreq_n  in  1  CPU IORQ, active-low.
- reg_addr_i  in  4  register select, from cpu_addr[3:0].
- data_i  in  8  CPU write data.
- timer_cs  in  1  chip select from the address decoder.
- uart_irq_i  in  1  UART receive-data-available, level.
- ext_irq_i  in  1  external interrupt request, level.
- data_o  out  8  register read data, or the vector during acknowledge.
- vec_cs_o  out  1  high while data_o carries the vector; the top-level mux selects data_o when it is high.
- int_n_o  out  1  Z80 INT, active-low.

Behaviour:
- Reset values:
  - All registers are 0, except MASK = 0x00 and VECTOR = 0x00.
  - Counter and prescaler are 0. Pending bits are 0.
  - int_n_o = 1, vec_cs_o = 0, data_o = 0x00.
- Write strobe:
  - wr_act = timer_cs & ~wr_n.
  - The write commits on the first cycle of wr_act only, i.e. on the rising edge of wr_act against its registered copy.
  - Holding wr_n low for several cycles produces exactly one write.
- Register map:
  - 0 CTRL: b0 run, b1 auto-reload, b7 global IE.
  - 1 RELOAD_LO.
  - 2 RELOAD_HI.
  - 3 PRESCALE.
  - 4 STATUS: pending[2:0]; write-1-to-clear.
  - 5 MASK: [2:0].
  - 6 VECTOR: base; bits [7:3] are used.
  - 7 COUNT_LO: read-only. Reading it latches COUNT_HI into a shadow register.
  - 8 COUNT_HI: read-only; returns the shadow.
  - 9–15: read 0x00, writes ignored.
- Read path: data_o is registered and updates every cycle from reg_addr_i. The 1-cycle latency is covered by the Z80 T2/T3 timing.
- Timer operation:
  - Writing CTRL.run = 1 (0→1 transition) loads counter = RELOAD and prescaler = 0.
  - While run = 1, the prescaler counts 0..PRESCALE. On wrap it issues a tick, giving a period of PRESCALE+1 clocks.
  - Each tick decrements the counter.
  - A tick while counter == 0 sets pending[0] and then:
    - auto-reload = 1: reloads the counter from RELOAD.
    - auto-reload = 0: clears run and holds the counter at 0.
  - RELOAD = 0 with auto-reload gives one interrupt per tick.
  - Writing run = 0 freezes the counter.
- UART and external sources: uart_irq_i and ext_irq_i are synchronised through 2 flops. A rising edge sets pending[1] or pending[2] respectively. Level held high produces no retrigger.
- Interrupt output: int_n_o = ~(IE & |(pending & MASK)), registered, so it responds 1 cycle after the pending or mask change.
- Acknowledge:
  - Acknowledge is ~m1_n & ~ioreq_n.
  - On the first ack cycle, latch win = the lowest-index set bit of pending & MASK.
  - While ack is active: vec_cs_o = 1 and data_o = {VECTOR[7:3], win[1:0], 1'b0}.
  - On the ack falling edge, clear pending[win].
  - If nothing is enabled at ack time (spurious ack), the vector uses win = 3 and nothing is cleared.
- Simultaneous events: a set beats a clear in the same cycle. This covers a STATUS W1C write or an ack clear coinciding with a new event.
- Reset mid-operation: a synchronous return to the reset values on the next edge, including during ack. An in-flight write is discarded.

Decomposition:
- Shared package nanoz80_pkg holds:
  - register offset constants: REG_CTRL, REG_RELOAD_LO, REG_RELOAD_HI, REG_PRESCALE, REG_STATUS, REG_MASK, REG_VECTOR, REG_COUNT_LO, REG_COUNT_HI;
  - CTRL bit indices;
  - source index constants: SRC_TIMER, SRC_UART, SRC_EXT.
- One sub-module, irq_prio_enc: a combinational lowest-index priority encoder with valid output, reusable by future controllers.

Test Plan:
- Reset release → int_n_o = 1, vec_cs_o = 0, read of STATUS = 0x00, COUNT = 0x0000.
- PRESCALE = 3, RELOAD = 0x0002, CTRL = 0x83, MASK = 0x01 → pending[0] sets every 12 clocks ((2+1)×4); int_n_o falls 1 cycle after the set.
- With the timer interrupt pending and VECTOR = 0x40, drive m1_n = ioreq_n = 0 for 3 cycles → vec_cs_o = 1, data_o = 0x40; after release, STATUS = 0x00 and int_n_o = 1.
- uart_irq_i and ext_irq_i rise in the same cycle, MASK = 0x06, IE = 1 → ack returns vector base|0x02 (UART), then the next ack returns base|0x04.
- wr_n held low for 4 cycles writing STATUS = 0x01 while a timer tick sets pending[0] on that first cycle → pending[0] stays 1; exactly one write committed.
- Auto-reload = 0, RELOAD = 1, PRESCALE = 0 → a single pending[0] after 2 clocks, CTRL.run reads 0, COUNT holds at 0x0000; rst_n_i low mid-count → all values reset next edge.
